// File: rtl/d_mem_ws_if.sv
// rtl/d_mem_ws_if.sv - request/response bundle between the datapath and d_mem_ws
interface d_mem_ws_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Fault;

  modport master (
    output Address, WriteData, MemRead, MemWrite, Size, Unsigned,
    input  ReadData, Ready, Fault
  );

  modport slave (
    input  Address, WriteData, MemRead, MemWrite, Size, Unsigned,
    output ReadData, Ready, Fault
  );
endinterface

// File: rtl/d_mem_ws.sv
// rtl/d_mem_ws.sv - clocked byte/half/word data memory with wait states and fault pulse
// Optional alignment fault enabled by defining D_MEM_ALIGN_CHECK_EN.
module d_mem_ws #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input logic        clk,
  input logic        rst_n,
  d_mem_ws_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        uns_q, rd_q, wr_q;
  logic [31:0] read_data_q;
  logic        fault_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, complete;
  logic [31:0] op_addr, op_wdata;
  logic [1:0]  op_size;
  logic        op_uns, op_rd, op_wr;
  logic        misalign, reject, do_read, do_write;
  logic [AW-1:0] idx;
  logic [31:0] mem_word, wr_word, rd_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign accept = (state_q == IDLE) && (bus.MemRead || bus.MemWrite);

  // With no wait states the access completes on the accept edge, so it works on live inputs.
  assign op_addr  = (WAIT_STATES == 0) ? bus.Address   : addr_q;
  assign op_wdata = (WAIT_STATES == 0) ? bus.WriteData : wdata_q;
  assign op_size  = (WAIT_STATES == 0) ? bus.Size      : size_q;
  assign op_uns   = (WAIT_STATES == 0) ? bus.Unsigned  : uns_q;
  assign op_rd    = (WAIT_STATES == 0) ? bus.MemRead   : rd_q;
  assign op_wr    = (WAIT_STATES == 0) ? bus.MemWrite  : wr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      BUSY: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q == 4'd1) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef D_MEM_ALIGN_CHECK_EN
  assign misalign = ((op_size == 2'b01) && op_addr[0]) ||
                    ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject   = (op_rd && op_wr) || (op_size == 2'b11) ||
                    (op_addr[31:2] >= 30'(DEPTH_WORDS)) || misalign;
  assign do_read  = complete && !reject && op_rd;
  // A write must never land on an edge seen while reset is asserted.
  assign do_write = complete && !reject && op_wr && rst_n;

  assign idx      = op_addr[AW+1:2];
  assign mem_word = mem[idx];
  assign byte_v   = mem_word[{op_addr[1:0], 3'b000} +: 8];
  assign half_v   = mem_word[{op_addr[1], 4'b0000} +: 16];

  always_comb begin
    wr_word = mem_word;
    rd_ext  = mem_word;
    case (op_size)
      2'b00: begin
        wr_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
        rd_ext = {{24{byte_v[7] & ~op_uns}}, byte_v};
      end
      2'b01: begin
        wr_word[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
        rd_ext = {{16{half_v[15] & ~op_uns}}, half_v};
      end
      2'b10:   wr_word = op_wdata;
      default: wr_word = mem_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      read_data_q <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.Address;
        wdata_q <= bus.WriteData;
        size_q  <= bus.Size;
        uns_q   <= bus.Unsigned;
        rd_q    <= bus.MemRead;
        wr_q    <= bus.MemWrite;
      end
      fault_q <= complete && reject;
      if (do_read) read_data_q <= rd_ext;
    end
  end

  assign bus.Ready    = (state_q == IDLE);
  assign bus.ReadData = read_data_q;
  assign bus.Fault    = fault_q;
endmodule
